// File: rtl/rf_write_arbiter.sv
// -----------------------------------------------------------------------------
// rf_write_arbiter
//   Arbitrates two writeback requesters (execute result path and memory load
//   path) onto the single decode-stage register-file write port. Each source
//   has a one-entry holding slot. Grants follow program order through an age
//   bit, and the write port is driven from registers. In-flight destinations
//   are reported so that decode can stall dependent reads.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   exe_valid/ready/id/data  execute-path request (valid/ready handshake)
//   mem_valid/ready/id/data  memory-path request (valid/ready handshake)
//   write_en/id/data         registered register-file write port
//   busy_mask                bit i set while register i is pending anywhere
//   contention_cnt           saturating count of cycles with both slots full
// -----------------------------------------------------------------------------
module rf_write_arbiter #(
   parameter int DATA_W = 32,
   parameter int ID_W   = 5,
   parameter int CNT_W  = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 exe_valid,
   output logic                 exe_ready,
   input  logic [ID_W-1:0]      exe_id,
   input  logic [DATA_W-1:0]    exe_data,
   input  logic                 mem_valid,
   output logic                 mem_ready,
   input  logic [ID_W-1:0]      mem_id,
   input  logic [DATA_W-1:0]    mem_data,
   output logic                 write_en,
   output logic [ID_W-1:0]      write_id,
   output logic [DATA_W-1:0]    write_data,
   output logic [2**ID_W-1:0]   busy_mask,
   output logic [CNT_W-1:0]     contention_cnt
);

   localparam int NREG = 2**ID_W;

   // Holding slots
   logic              e_full, m_full;
   logic [ID_W-1:0]   e_id, m_id;
   logic [DATA_W-1:0] e_data, m_data;
   logic              old_is_m;   // set when slot M holds the older entry

   logic grant_e, grant_m;
   logic exe_load, mem_load;
   logic e_held;

   // NOTE: every signal driven here gets a value on every path (defaults at
   // the top), so no latch is inferred.
   always_comb begin
      grant_m   = m_full && (!e_full || old_is_m);
      grant_e   = e_full && (!m_full || !old_is_m);
      exe_ready = !rst && (!e_full || grant_e);
      mem_ready = !rst && (!m_full || grant_m);
      // Writes to register 0 are accepted but dropped.
      exe_load  = exe_valid && exe_ready && (exe_id != '0);
      mem_load  = mem_valid && mem_ready && (mem_id != '0);
      // The E entry survives the edge untouched (full, not granted).
      e_held    = e_full && !grant_e;
   end

   always_comb begin
      busy_mask = '0;
      for (int i = 1; i < NREG; i++) begin
         busy_mask[i] = (e_full && (e_id == ID_W'(i))) ||
                        (m_full && (m_id == ID_W'(i))) ||
                        (write_en && (write_id == ID_W'(i)));
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // right-hand side below sees the pre-edge value regardless of order.
   always_ff @(posedge clk) begin
      if (rst) begin
         e_full         <= 1'b0;
         m_full         <= 1'b0;
         e_id           <= '0;
         m_id           <= '0;
         e_data         <= '0;
         m_data         <= '0;
         old_is_m       <= 1'b0;
         write_en       <= 1'b0;
         write_id       <= '0;
         write_data     <= '0;
         contention_cnt <= '0;
      end else begin
         // A load wins over the clear, so grant+accept on one source reloads.
         if (exe_load) begin
            e_full <= 1'b1;
            e_id   <= exe_id;
            e_data <= exe_data;
         end else if (grant_e) begin
            e_full <= 1'b0;
         end

         if (mem_load) begin
            m_full <= 1'b1;
            m_id   <= mem_id;
            m_data <= mem_data;
         end else if (grant_m) begin
            m_full <= 1'b0;
         end

         // M is older unless an E entry was already waiting: an entry that
         // stays put is older than any newcomer, and on a simultaneous fill
         // the memory-stage instruction precedes the execute-stage one.
         // Meaningless while fewer than two slots are full.
         old_is_m <= !e_held;

         if (grant_m) begin
            write_en   <= 1'b1;
            write_id   <= m_id;
            write_data <= m_data;
         end else if (grant_e) begin
            write_en   <= 1'b1;
            write_id   <= e_id;
            write_data <= e_data;
         end else begin
            write_en   <= 1'b0;
         end

         if (e_full && m_full && (contention_cnt != '1))
            contention_cnt <= contention_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rf_write_arbiter
//   Self-checking bench for rf_write_arbiter. Accepted non-zero requests are
//   pushed to an expected-write queue in program order (memory before execute
//   on the same edge); every write_en pulse pops and compares. Directed cycle
//   checks cover latency, readies, busy_mask and the contention counter.
// -----------------------------------------------------------------------------
module tb_rf_write_arbiter;

   localparam int DATA_W = 32;
   localparam int ID_W   = 5;
   localparam int CNT_W  = 16;

   typedef struct {
      logic [ID_W-1:0]   id;
      logic [DATA_W-1:0] data;
   } exp_t;

   logic              clk = 1'b0;
   logic              rst;
   logic              exe_valid, mem_valid;
   logic              exe_ready, mem_ready;
   logic [ID_W-1:0]   exe_id, mem_id;
   logic [DATA_W-1:0] exe_data, mem_data;
   logic              write_en;
   logic [ID_W-1:0]   write_id;
   logic [DATA_W-1:0] write_data;
   logic [2**ID_W-1:0] busy_mask;
   logic [CNT_W-1:0]  contention_cnt;

   int errors = 0;
   int checks = 0;

   exp_t              exp_q[$];
   logic [DATA_W-1:0] reg_model [2**ID_W];

   rf_write_arbiter #(.DATA_W(DATA_W), .ID_W(ID_W), .CNT_W(CNT_W)) dut (
      .clk            (clk),
      .rst            (rst),
      .exe_valid      (exe_valid),
      .exe_ready      (exe_ready),
      .exe_id         (exe_id),
      .exe_data       (exe_data),
      .mem_valid      (mem_valid),
      .mem_ready      (mem_ready),
      .mem_id         (mem_id),
      .mem_data       (mem_data),
      .write_en       (write_en),
      .write_id       (write_id),
      .write_data     (write_data),
      .busy_mask      (busy_mask),
      .contention_cnt (contention_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] actual,
                        input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)",
                  tag, actual, expected, $time);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      exe_valid = 1'b0;
      mem_valid = 1'b0;
      exe_id    = '0;
      mem_id    = '0;
      exe_data  = '0;
      mem_data  = '0;
   endtask

   // Scoreboard producer: record accepted requests in program order.
   always @(posedge clk) begin
      if (rst) begin
         exp_q.delete();
      end else begin
         if (mem_valid && mem_ready && mem_id != '0)
            exp_q.push_back('{id: mem_id, data: mem_data});
         if (exe_valid && exe_ready && exe_id != '0)
            exp_q.push_back('{id: exe_id, data: exe_data});
      end
   end

   // Scoreboard consumer: every port write must match the oldest expectation.
   always @(negedge clk) begin
      if (write_en) begin
         if (exp_q.size() == 0) begin
            check("spurious_write_en", 64'(write_en), 64'd0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("sb_write_id", 64'(write_id), 64'(e.id));
            check("sb_write_data", 64'(write_data), 64'(e.data));
            reg_model[write_id] = write_data;
         end
      end
   end

   initial begin
      for (int i = 0; i < 2**ID_W; i++) reg_model[i] = '0;
      idle();
      rst = 1'b1;
      tick();
      tick();

      // Reset state
      check("rst_exe_ready", 64'(exe_ready), 64'd0);
      check("rst_mem_ready", 64'(mem_ready), 64'd0);
      check("rst_write_en", 64'(write_en), 64'd0);
      check("rst_write_id", 64'(write_id), 64'd0);
      check("rst_write_data", 64'(write_data), 64'd0);
      check("rst_busy", 64'(busy_mask), 64'd0);
      check("rst_cnt", 64'(contention_cnt), 64'd0);
      rst = 1'b0;
      #1;
      check("post_rst_exe_ready", 64'(exe_ready), 64'd1);
      check("post_rst_mem_ready", 64'(mem_ready), 64'd1);
      tick();

      // Single write: accepted in cycle 1, port in cycle 3
      exe_valid = 1'b1; exe_id = 5'd5; exe_data = 32'hDEADBEEF;
      check("single_ready", 64'(exe_ready), 64'd1);
      tick();
      idle();
      check("single_c2_busy5", 64'(busy_mask[5]), 64'd1);
      check("single_c2_we", 64'(write_en), 64'd0);
      tick();
      check("single_c3_we", 64'(write_en), 64'd1);
      check("single_c3_id", 64'(write_id), 64'd5);
      check("single_c3_data", 64'(write_data), 64'hDEADBEEF);
      check("single_c3_busy5", 64'(busy_mask[5]), 64'd1);
      tick();
      check("single_c4_busy5", 64'(busy_mask[5]), 64'd0);
      check("single_c4_we", 64'(write_en), 64'd0);
      tick();

      // Simultaneous, different ids: M first, then E
      mem_valid = 1'b1; mem_id = 5'd3; mem_data = 32'h11;
      exe_valid = 1'b1; exe_id = 5'd4; exe_data = 32'h22;
      tick();
      idle();
      check("sim_exe_ready_low", 64'(exe_ready), 64'd0);
      check("sim_mem_ready_high", 64'(mem_ready), 64'd1);
      check("sim_busy", 64'(busy_mask), 64'h18);
      tick();
      check("sim_first_id", 64'(write_id), 64'd3);
      check("sim_exe_ready_back", 64'(exe_ready), 64'd1);
      check("sim_cnt", 64'(contention_cnt), 64'd1);
      tick();
      check("sim_second_we", 64'(write_en), 64'd1);
      check("sim_second_id", 64'(write_id), 64'd4);
      tick();
      tick();

      // Same id, same cycle: 0xAA then 0xBB, final content 0xBB
      mem_valid = 1'b1; mem_id = 5'd7; mem_data = 32'hAA;
      exe_valid = 1'b1; exe_id = 5'd7; exe_data = 32'hBB;
      tick();
      idle();
      tick();
      check("same_first_data", 64'(write_data), 64'hAA);
      tick();
      check("same_second_data", 64'(write_data), 64'hBB);
      tick();
      check("same_final_model", 64'(reg_model[7]), 64'hBB);
      check("same_cnt", 64'(contention_cnt), 64'd2);

      // x0 discard
      exe_valid = 1'b1; exe_id = 5'd0; exe_data = 32'h55;
      check("x0_ready", 64'(exe_ready), 64'd1);
      tick();
      idle();
      for (int c = 0; c < 3; c++) begin
         check("x0_busy", 64'(busy_mask), 64'd0);
         check("x0_we", 64'(write_en), 64'd0);
         check("x0_ready_held", 64'(exe_ready), 64'd1);
         tick();
      end

      // Back-to-back streaming, ids 1..8
      for (int c = 0; c < 11; c++) begin
         if (c >= 2 && c <= 9) check("stream_we", 64'(write_en), 64'd1);
         if (c == 10) check("stream_we_end", 64'(write_en), 64'd0);
         if (c < 8) begin
            exe_valid = 1'b1;
            exe_id    = ID_W'(c + 1);
            exe_data  = 32'h1000 + 32'(c);
            check("stream_ready", 64'(exe_ready), 64'd1);
         end else begin
            idle();
         end
         tick();
      end

      // Reset mid-operation with both slots full
      mem_valid = 1'b1; mem_id = 5'd9;  mem_data = 32'h99;
      exe_valid = 1'b1; exe_id = 5'd10; exe_data = 32'hAB;
      tick();
      idle();
      check("midrst_busy_full", 64'(busy_mask), 64'h600);
      rst = 1'b1;
      #1;
      check("midrst_exe_ready", 64'(exe_ready), 64'd0);
      check("midrst_mem_ready", 64'(mem_ready), 64'd0);
      tick();
      check("midrst_we", 64'(write_en), 64'd0);
      check("midrst_id", 64'(write_id), 64'd0);
      check("midrst_data", 64'(write_data), 64'd0);
      check("midrst_busy", 64'(busy_mask), 64'd0);
      check("midrst_cnt", 64'(contention_cnt), 64'd0);
      rst = 1'b0;
      #1;
      check("midrst_exe_ready_back", 64'(exe_ready), 64'd1);
      check("midrst_mem_ready_back", 64'(mem_ready), 64'd1);
      for (int c = 0; c < 3; c++) begin
         tick();
         check("midrst_no_we", 64'(write_en), 64'd0);
      end

      check("sb_drained", 64'(exp_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/rf_write_arbiter.md
# rf_write_arbiter

Register-file write-port arbiter for the decode stage. Two writeback requesters (execute-stage result path and memory-stage load path) compete for the single decode-stage write port (`write_en`/`write_id`/`write_data`). Each requester has a one-entry holding slot. Grants preserve program order, the write port is driven from registers, and the block reports in-flight destination registers so decode can stall dependent reads.

## Interface
- `DATA_W`, default 32: write data width.
- `ID_W`, default 5: register index width; the register file has 2**ID_W entries.
- `CNT_W`, default 16: width of the contention counter.

- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `exe_valid`  in  1: execute-path write request.
- `exe_ready`  out  1: execute-path request accepted this cycle when high together with `exe_valid`.
- `exe_id`  in  ID_W: execute-path destination register.
- `exe_data`  in  DATA_W: execute-path write data.
- `mem_valid`, `mem_ready`, `mem_id`, `mem_data`: same as the `exe_*` group, for the memory/load path.
- `write_en`  out  1: registered write strobe to the decode-stage register file.
- `write_id`  out  ID_W: registered destination register.
- `write_data`  out  DATA_W: registered write data.
- `busy_mask`  out  2**ID_W: bit i high when register i is held in any slot or in the output register.
- `contention_cnt`  out  CNT_W: saturating count of cycles in which both slots are full.

## Operation
- State: slot E (execute) and slot M (memory). Each slot holds full, id and data. One age bit, `old_is_m`. One output register. One counter.
- Accept: a source is accepted when valid && ready. Then ready_x = !rst && (!slot_x.full || grant_x).
- An accepted request with id == 0 is discarded. It never fills a slot and never produces `write_en`.
- Grant (combinational, at most one per cycle):
  - Only one slot full: grant that slot.
  - Both slots full: grant the older slot, as indicated by `old_is_m`.
- Age rule:
  - A slot that fills while the other slot is already full is younger.
  - If both slots fill on the same edge, M is older, because the memory-stage instruction precedes the execute-stage instruction.
- On the granted edge:
  - The output register loads the slot id and data, with `write_en` = 1.
  - The slot clears, unless the same source is accepted on that edge, in which case the slot reloads with the new request.
- No grant on an edge: `write_en` = 0 on the next cycle. `write_id` and `write_data` hold their last values.
- Same-id ordering: the older write reaches the port first, so the younger value is the final register content.
- `busy_mask` is combinational from the slot full/id fields and the output register (`write_en`, `write_id`). Bit 0 is always 0.
- `contention_cnt` increments on every edge where both slots are full and saturates at 2**CNT_W-1.

## Timing
- Minimum latency, request to port: accepted in cycle T → slot full in T+1 → granted in T+1 → `write_en` high in T+2.
- Throughput: one register write per cycle in total. Each source sustains one accept per cycle while it wins arbitration.
- Contention:
  - The losing slot stays full and its ready stays low.
  - The loser becomes older and is granted in the next cycle.
  - Maximum wait is one cycle.
- Simultaneous grant and accept on the same source: the slot is reloaded, not cleared, and the new entry is younger than any full entry in the other slot.
- Reset, evaluated when `rst` is high at an edge:
  - Slots empty, `old_is_m` = 0.
  - `write_en` = 0, `write_id` = 0, `write_data` = 0.
  - `contention_cnt` = 0, `busy_mask` = 0.
  - Both readies are low while `rst` is high.
- Reset mid-operation: pending writes are dropped and no `write_en` pulse follows. Both readies return high in the first cycle after `rst` deasserts.

## Test plan
- Single write: exe (id 5, 0xDEADBEEF) accepted in cycle 1 → `write_en`=1, `write_id`=5, `write_data`=0xDEADBEEF in cycle 3; `busy_mask[5]` high in cycles 2–3, low in cycle 4.
- Simultaneous, different ids: mem (id 3, 0x11) and exe (id 4, 0x22) in the same cycle → port writes id 3 then id 4 on consecutive cycles; `exe_ready` low for one cycle; `contention_cnt` = 1.
- Same id, same cycle: mem (id 7, 0xAA) and exe (id 7, 0xBB) → 0xAA written, then 0xBB; a register model ends at 0xBB.
- x0 discard: exe (id 0, 0x55) → no `write_en`; `busy_mask` stays 0; `exe_ready` stays high.
- Back-to-back streaming: exe valid for 8 cycles (ids 1–8), mem idle → 8 consecutive `write_en` pulses in order; `exe_ready` never low.
- Reset mid-operation: both slots full, `rst` high for one edge → no further `write_en`; all outputs 0; both readies high in the first cycle after `rst` deasserts.
